// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, operation
// encoding and mstatus field positions.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    RW   = 2'b01,
    RS   = 2'b10,
    RC   = 2'b11
  } csr_op_e;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit software write ports;
// a write to either half takes precedence over the increment in that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (wr_lo) begin
      value[31:0] <= wdata;
    end else if (wr_hi) begin
      value[63:32] <= wdata;
    end else if (inc) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR register file: CSRRW/CSRRS/CSRRC read-modify-write, trap
// state and trap vector. Define CSR_COUNTERS_EN to build mcycle/minstret.
module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        illegal_csr,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret,
  input  logic        instret,
  output logic [31:0] trap_vector,
  output logic [31:0] epc
);

  csr_op_e     op;
  logic        mie, mpie;
  logic [31:0] mtvec, mscratch, mepc, mcause;
  logic [31:0] mstatus_rd;
  logic [31:0] wnew;
  logic        mapped, wr_attempt, wr_en;

  assign op = csr_op_e'(csr_op);

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_rd[MSTATUS_MIE]  = mie;
    mstatus_rd[MSTATUS_MPIE] = mpie;
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] cyc_val, ins_val;

  csr_counter64 u_cycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (wr_en && csr_addr == CSR_MCYCLE),
    .wr_hi (wr_en && csr_addr == CSR_MCYCLEH),
    .wdata (wnew),
    .value (cyc_val)
  );

  csr_counter64 u_instret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (instret),
    .wr_lo (wr_en && csr_addr == CSR_MINSTRET),
    .wr_hi (wr_en && csr_addr == CSR_MINSTRETH),
    .wdata (wnew),
    .value (ins_val)
  );
`else
  logic unused_instret;
  assign unused_instret = instret;
`endif

  always_comb begin
    csr_rdata = '0;
    mapped    = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = mstatus_rd;
      CSR_MTVEC:    csr_rdata = mtvec;
      CSR_MSCRATCH: csr_rdata = mscratch;
      CSR_MEPC:     csr_rdata = mepc;
      CSR_MCAUSE:   csr_rdata = mcause;
      CSR_MHARTID:  csr_rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    csr_rdata = cyc_val[31:0];
      CSR_MCYCLEH:   csr_rdata = cyc_val[63:32];
      CSR_MINSTRET:  csr_rdata = ins_val[31:0];
      CSR_MINSTRETH: csr_rdata = ins_val[63:32];
`else
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: csr_rdata = '0;
`endif
      default:      mapped = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      RW:      wnew = csr_wdata;
      RS:      wnew = csr_rdata | csr_wdata;
      RC:      wnew = csr_rdata & ~csr_wdata;
      default: wnew = csr_rdata;
    endcase
  end

  // RS/RC with a zero mask is a pure read, so it can neither write nor trip
  // the read-only check on mhartid.
  assign wr_attempt  = (op == RW) || ((op != NONE) && (csr_wdata != '0));
  assign illegal_csr = ((op != NONE) && !mapped) ||
                       (wr_attempt && csr_addr == CSR_MHARTID);
  assign wr_en       = wr_attempt && mapped && (csr_addr != CSR_MHARTID) &&
                       !trap_req && !mret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RESET & ~32'd3;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else if (trap_req) begin
      mepc   <= trap_pc & ~32'd3;
      mcause <= trap_cause;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (mret) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie  <= wnew[MSTATUS_MIE];
          mpie <= wnew[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec    <= wnew & ~32'd3;
        CSR_MSCRATCH: mscratch <= wnew;
        CSR_MEPC:     mepc     <= wnew & ~32'd3;
        CSR_MCAUSE:   mcause   <= wnew;
        default: ;
      endcase
    end
  end

  assign trap_vector = mtvec;
  assign epc         = mepc;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized CSR
// traffic compared against a behavioural model of the machine-mode CSRs.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        illegal_csr;
  logic        trap_req, mret, instret;
  logic [31:0] trap_cause, trap_pc, trap_vector, epc;

  localparam logic [31:0] HID = 32'h0000_0005;

  int checks = 0;
  int failures = 0;

  csr_file #(.MTVEC_RESET(32'h0000_0103), .HART_ID(HID)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .illegal_csr (illegal_csr),
    .trap_req    (trap_req),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .mret        (mret),
    .instret     (instret),
    .trap_vector (trap_vector),
    .epc         (epc)
  );

  always #5 clk = ~clk;

  // Reference state: architectural values as software sees them.
  logic [31:0] m_status, m_tvec, m_scratch, m_epc, m_cause;
  logic [63:0] m_cyc, m_ins;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_status  = 32'h0000_1800;
    m_tvec    = 32'h0000_0100;
    m_scratch = 0;
    m_epc     = 0;
    m_cause   = 0;
    m_cyc     = 0;
    m_ins     = 0;
  endtask

  function automatic bit m_mapped(input logic [11:0] a);
    case (a)
      12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
      12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_status;
      12'h305: return m_tvec;
      12'h340: return m_scratch;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'hF14: return HID;
`ifdef CSR_COUNTERS_EN
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
`endif
      default: return 0;
    endcase
  endfunction

  task automatic model_clock(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                             input logic tr, input logic [31:0] tc, input logic [31:0] tp,
                             input logic mr, input logic ir);
    logic [31:0] oldv, newv;
    logic [63:0] ncyc, nins;
    bit          wr;
    oldv = m_read(a);
    newv = (op == 2'd1) ? wd : (op == 2'd2) ? (oldv | wd) : (oldv & ~wd);
    wr   = (op != 0) && m_mapped(a) && (op == 2'd1 || wd != 0) && a != 12'hF14 && !tr && !mr;
    ncyc = m_cyc + 64'd1;
    nins = ir ? m_ins + 64'd1 : m_ins;
    if (tr) begin
      m_epc    = tp & ~32'd3;
      m_cause  = tc;
      m_status = 32'h1800 | (m_status[3] ? 32'h80 : 32'h0);
    end else if (mr) begin
      m_status = 32'h1880 | (m_status[7] ? 32'h8 : 32'h0);
    end else if (wr) begin
      case (a)
        12'h300: m_status = 32'h1800 | (newv & 32'h88);
        12'h305: m_tvec = newv & ~32'd3;
        12'h340: m_scratch = newv;
        12'h341: m_epc = newv & ~32'd3;
        12'h342: m_cause = newv;
        12'hB00: ncyc = {m_cyc[63:32], newv};
        12'hB80: ncyc = {newv, m_cyc[31:0]};
        12'hB02: nins = {m_ins[63:32], newv};
        12'hB82: nins = {newv, m_ins[31:0]};
        default: ;
      endcase
    end
`ifdef CSR_COUNTERS_EN
    m_cyc = ncyc;
    m_ins = nins;
`endif
  endtask

  // Called at a negedge; drives one cycle, checks outputs mid-cycle, returns at the next negedge.
  task automatic step(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                      input logic tr, input logic [31:0] tc, input logic [31:0] tp,
                      input logic mr, input logic ir,
                      output logic [31:0] rd, output logic ill);
    csr_op = op; csr_addr = a; csr_wdata = wd;
    trap_req = tr; trap_cause = tc; trap_pc = tp; mret = mr; instret = ir;
    #1;
    chk("rdata", csr_rdata, m_read(a));
    chk("illegal", illegal_csr,
        ((op != 0) && !m_mapped(a)) || (a == 12'hF14 && (op == 2'd1 || (op != 0 && wd != 0))));
    chk("trap_vector", trap_vector, m_tvec);
    chk("epc", epc, m_epc);
    rd  = csr_rdata;
    ill = illegal_csr;
    @(posedge clk);
    model_clock(op, a, wd, tr, tc, tp, mr, ir);
    @(negedge clk);
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic ill);
    step(op, a, wd, 1'b0, 0, 0, 1'b0, 1'b0, rd, ill);
  endtask

  logic [31:0] rd;
  logic        ill;
  logic [11:0] addrs [12] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                              12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h301};

  initial begin
    rst_n = 1'b0; csr_op = 0; csr_addr = 12'h300; csr_wdata = 0;
    trap_req = 0; trap_cause = 0; trap_pc = 0; mret = 0; instret = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_trap_vector", trap_vector, 32'h0000_0100);
    chk("rst_epc", epc, 32'h0);
    chk("rst_mstatus", csr_rdata, 32'h0000_1800);
    chk("rst_illegal", illegal_csr, 1'b0);
    csr_addr = 12'h341;
    #1;
    chk("rst_mepc", csr_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // mscratch read-modify-write sequence
    csr(2'd1, 12'h340, 32'hDEAD_BEEF, rd, ill); chk("rw_old", rd, 32'h0);
    csr(2'd2, 12'h340, 32'h0000_0010, rd, ill); chk("rs_old", rd, 32'hDEAD_BEEF);
    csr(2'd3, 12'h340, 32'hDEAD_0000, rd, ill); chk("rc_old", rd, 32'hDEAD_BEFF);
    csr(2'd2, 12'h340, 32'h0, rd, ill);
    chk("rc_final", rd, 32'h0000_BEFF);
    chk("rs_zero_legal", ill, 1'b0);

    // trap entry and mret
    csr(2'd2, 12'h300, 32'h8, rd, ill);
    step(2'd0, 12'h300, 0, 1'b1, 32'd11, 32'h0000_0206, 1'b0, 1'b0, rd, ill);
    chk("trap_epc", epc, 32'h0000_0204);
    csr(2'd2, 12'h342, 0, rd, ill); chk("trap_mcause", rd, 32'd11);
    csr(2'd2, 12'h300, 0, rd, ill); chk("trap_mstatus", rd, 32'h0000_1880);
    step(2'd0, 12'h300, 0, 1'b0, 0, 0, 1'b1, 1'b0, rd, ill);
    csr(2'd2, 12'h300, 0, rd, ill); chk("mret_mstatus", rd, 32'h0000_1888);

    // write dropped under a same-cycle trap
    step(2'd1, 12'h340, 32'h1234_5678, 1'b1, 32'd2, 32'h0000_0333, 1'b0, 1'b0, rd, ill);
    csr(2'd2, 12'h340, 0, rd, ill); chk("trap_drops_write", rd, 32'h0000_BEFF);
    chk("trap_same_epc", epc, 32'h0000_0330);

    // 64-bit counter carry across halves
    csr(2'd1, 12'hB00, 32'hFFFF_FFFF, rd, ill);
    csr(2'd1, 12'hB80, 32'h0, rd, ill);
    chk("cnt_write_legal", ill, 1'b0);
    csr(2'd0, 12'h300, 0, rd, ill);
    csr(2'd2, 12'hB00, 0, rd, ill);
`ifdef CSR_COUNTERS_EN
    chk("mcycle_wrap", rd, 32'h0);
    csr(2'd2, 12'hB80, 0, rd, ill); chk("mcycleh_carry", rd, 32'h1);
`else
    chk("mcycle_absent", rd, 32'h0);
`endif

    // read-only and unmapped addresses
    csr(2'd1, 12'hF14, 32'h1, rd, ill);
    chk("mhartid_ro_ill", ill, 1'b1);
    chk("mhartid_val", rd, HID);
    csr(2'd2, 12'h7C0, 0, rd, ill);
    chk("unmapped_rd", rd, 32'h0);
    chk("unmapped_ill", ill, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] wd;
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      step(2'($urandom_range(0, 3)), addrs[$urandom_range(0, 11)], wd,
           $urandom_range(0, 15) == 0, $urandom, $urandom,
           $urandom_range(0, 15) == 0, 1'($urandom), rd, ill);
    end

    // asynchronous reset mid-cycle discards the pending write
    csr_op = 2'd1; csr_addr = 12'h340; csr_wdata = 32'hA5A5_A5A5;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_mscratch", csr_rdata, 32'h0);
    chk("async_rst_tvec", trap_vector, 32'h0000_0100);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    csr(2'd2, 12'h340, 0, rd, ill); chk("rst_drops_write", rd, 32'h0);
    for (int i = 0; i < 50; i++) begin
      step(2'($urandom_range(0, 3)), addrs[$urandom_range(0, 11)], $urandom,
           $urandom_range(0, 15) == 0, $urandom, $urandom,
           $urandom_range(0, 15) == 0, 1'($urandom), rd, ill);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
